// File: rtl/acl_txbuf_ctrl.sv
// rtl/acl_txbuf_ctrl.sv - ping-pong ACL TX payload buffer controller
// Chooses the buffer the payload encoder reads from ARQ decisions and returns ACKed buffers to the MCU.
module acl_txbuf_ctrl #(
   parameter int LEN_W = 10
) (
   input  logic             clk_6M,
   input  logic             rstz,
   input  logic             m_2active_p,
   input  logic             s_2active_p,
   input  logic             pk_encode,
   input  logic             header_st_p,
   input  logic             sendnewpy,
   input  logic             sendoldpy,
   input  logic             send0py,
   input  logic             mcu_wr_p,
   input  logic [LEN_W-1:0] mcu_wr_len,
   input  logic [1:0]       mcu_wr_llid,
   input  logic             mcu_flush_p,
   output logic             txbuf_sel,
   output logic             tx_haspy,
   output logic [LEN_W-1:0] tx_pylen,
   output logic [1:0]       tx_llid,
   output logic [1:0]       buf_state0,
   output logic [1:0]       buf_state1,
   output logic             buf_freed_p,
   output logic             wr_err_p
);

   localparam logic [1:0] ST_FREE     = 2'd0;
   localparam logic [1:0] ST_LOADED   = 2'd1;
   localparam logic [1:0] ST_INFLIGHT = 2'd2;

   logic [1:0][1:0]       st_q, st_d;
   logic [1:0][LEN_W-1:0] len_q, len_d;
   logic [1:0][1:0]       llid_q, llid_d;
   logic                  cur_q, cur_d, ncur;
   logic                  haspy_d;
   logic [LEN_W-1:0]      pylen_d;
   logic [1:0]            txllid_d;
   logic                  freed_d, err_d;
   logic                  decide, activate, wr_tgt;

   assign ncur     = ~cur_q;
   assign decide   = pk_encode & header_st_p;
   assign activate = m_2active_p | s_2active_p;

   // Decision, then flush, then write: all judged against pre-cycle state where ordering matters.
   always_comb begin
      st_d     = st_q;
      len_d    = len_q;
      llid_d   = llid_q;
      cur_d    = cur_q;
      haspy_d  = tx_haspy;
      pylen_d  = tx_pylen;
      txllid_d = tx_llid;
      freed_d  = 1'b0;
      err_d    = 1'b0;
      wr_tgt   = ncur;

      if (decide) begin
         if (send0py | sendnewpy) begin
            if (st_q[0] == ST_INFLIGHT) begin
               st_d[0] = ST_FREE;
               freed_d = 1'b1;
            end
            if (st_q[1] == ST_INFLIGHT) begin
               st_d[1] = ST_FREE;
               freed_d = 1'b1;
            end
         end
         if (send0py) begin
            haspy_d  = 1'b1;
            pylen_d  = '0;
            txllid_d = 2'b01;
         end else if (sendnewpy) begin
            if (st_q[ncur] == ST_LOADED) begin
               st_d[ncur] = ST_INFLIGHT;
               cur_d      = ncur;
               haspy_d    = 1'b1;
               pylen_d    = len_q[ncur];
               txllid_d   = llid_q[ncur];
            end else begin
               haspy_d = 1'b0;
               pylen_d = '0;
            end
         end else if (sendoldpy) begin
            if (st_q[cur_q] == ST_INFLIGHT) begin
               haspy_d  = 1'b1;
               pylen_d  = len_q[cur_q];
               txllid_d = llid_q[cur_q];
            end else begin
               haspy_d = 1'b0;
            end
         end else begin
            haspy_d = 1'b0;
         end
      end

      // A buffer promoted by this cycle's decision is already INFLIGHT and escapes the flush.
      if (mcu_flush_p) begin
         if (st_d[0] == ST_LOADED) begin
            st_d[0] = ST_FREE;
            freed_d = 1'b1;
         end
         if (st_d[1] == ST_LOADED) begin
            st_d[1] = ST_FREE;
            freed_d = 1'b1;
         end
      end

      if (mcu_wr_p) begin
         if ((st_q[ncur] == ST_FREE) || (st_q[cur_q] == ST_FREE)) begin
            wr_tgt         = (st_q[ncur] == ST_FREE) ? ncur : cur_q;
            st_d[wr_tgt]   = ST_LOADED;
            len_d[wr_tgt]  = mcu_wr_len;
            llid_d[wr_tgt] = mcu_wr_llid;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         st_q        <= '0;
         len_q       <= '0;
         llid_q      <= '0;
         cur_q       <= 1'b0;
         tx_haspy    <= 1'b0;
         tx_pylen    <= '0;
         tx_llid     <= 2'b00;
         buf_freed_p <= 1'b0;
         wr_err_p    <= 1'b0;
      end else if (activate) begin
         st_q        <= '0;
         cur_q       <= 1'b0;
         tx_haspy    <= 1'b0;
         tx_pylen    <= '0;
         tx_llid     <= 2'b00;
         buf_freed_p <= 1'b0;
         wr_err_p    <= 1'b0;
      end else begin
         st_q        <= st_d;
         len_q       <= len_d;
         llid_q      <= llid_d;
         cur_q       <= cur_d;
         tx_haspy    <= haspy_d;
         tx_pylen    <= pylen_d;
         tx_llid     <= txllid_d;
         buf_freed_p <= freed_d;
         wr_err_p    <= err_d;
      end
   end

   assign txbuf_sel  = cur_q;
   assign buf_state0 = st_q[0];
   assign buf_state1 = st_q[1];

endmodule

// File: tb/tb_acl_txbuf_ctrl.sv
// tb/tb_acl_txbuf_ctrl.sv - self-checking bench for acl_txbuf_ctrl
// Directed scenarios against hand-derived values, then random traffic against a reference model.
module tb_acl_txbuf_ctrl;

   localparam logic [1:0] FREE = 2'd0, LOADED = 2'd1, INFL = 2'd2;

   logic       clk_6M = 1'b0;
   logic       rstz = 1'b0;
   logic       m_2active_p = 0, s_2active_p = 0, pk_encode = 0, header_st_p = 0;
   logic       sendnewpy = 0, sendoldpy = 0, send0py = 0, mcu_wr_p = 0, mcu_flush_p = 0;
   logic [9:0] mcu_wr_len = '0;
   logic [1:0] mcu_wr_llid = '0;
   logic       txbuf_sel, tx_haspy, buf_freed_p, wr_err_p;
   logic [9:0] tx_pylen;
   logic [1:0] tx_llid, buf_state0, buf_state1;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [1:0] m_st [2];
   logic [9:0] m_len [2];
   logic [1:0] m_llid [2];
   logic       m_cur, m_haspy, m_freed, m_err;
   logic [9:0] m_pylen;
   logic [1:0] m_txllid;

   acl_txbuf_ctrl #(.LEN_W(10)) dut (
      .clk_6M(clk_6M), .rstz(rstz), .m_2active_p(m_2active_p), .s_2active_p(s_2active_p),
      .pk_encode(pk_encode), .header_st_p(header_st_p), .sendnewpy(sendnewpy),
      .sendoldpy(sendoldpy), .send0py(send0py), .mcu_wr_p(mcu_wr_p), .mcu_wr_len(mcu_wr_len),
      .mcu_wr_llid(mcu_wr_llid), .mcu_flush_p(mcu_flush_p), .txbuf_sel(txbuf_sel),
      .tx_haspy(tx_haspy), .tx_pylen(tx_pylen), .tx_llid(tx_llid), .buf_state0(buf_state0),
      .buf_state1(buf_state1), .buf_freed_p(buf_freed_p), .wr_err_p(wr_err_p)
   );

   always #83 clk_6M = ~clk_6M;

   task automatic model_clear();
      m_st[0] = FREE; m_st[1] = FREE; m_cur = 0;
      m_haspy = 0; m_pylen = 0; m_txllid = 0; m_freed = 0; m_err = 0;
   endtask

   // One clock of behaviour, following the documented event ordering.
   task automatic model_step();
      logic [1:0] pre_st [2];
      logic       pre_cur, nxt;
      m_freed = 0;
      m_err   = 0;
      if (m_2active_p || s_2active_p) begin
         m_st[0] = FREE; m_st[1] = FREE; m_cur = 0;
         m_haspy = 0; m_pylen = 0; m_txllid = 0;
         return;
      end
      pre_st  = m_st;
      pre_cur = m_cur;
      nxt     = !pre_cur;
      if (pk_encode && header_st_p) begin
         if (send0py || sendnewpy)
            for (int b = 0; b < 2; b++)
               if (pre_st[b] == INFL) begin m_st[b] = FREE; m_freed = 1; end
         if (send0py) begin
            m_haspy = 1; m_pylen = 0; m_txllid = 2'b01;
         end else if (sendnewpy) begin
            if (pre_st[nxt] == LOADED) begin
               m_st[nxt] = INFL; m_cur = nxt;
               m_haspy = 1; m_pylen = m_len[nxt]; m_txllid = m_llid[nxt];
            end else begin
               m_haspy = 0; m_pylen = 0;
            end
         end else if (sendoldpy) begin
            if (pre_st[pre_cur] == INFL) begin
               m_haspy = 1; m_pylen = m_len[pre_cur]; m_txllid = m_llid[pre_cur];
            end else m_haspy = 0;
         end else m_haspy = 0;
      end
      if (mcu_flush_p)
         for (int b = 0; b < 2; b++)
            if (m_st[b] == LOADED) begin m_st[b] = FREE; m_freed = 1; end
      if (mcu_wr_p) begin
         if (pre_st[nxt] == FREE) begin
            m_st[nxt] = LOADED; m_len[nxt] = mcu_wr_len; m_llid[nxt] = mcu_wr_llid;
         end else if (pre_st[pre_cur] == FREE) begin
            m_st[pre_cur] = LOADED; m_len[pre_cur] = mcu_wr_len; m_llid[pre_cur] = mcu_wr_llid;
         end else m_err = 1;
      end
   endtask

   task automatic idle();
      m_2active_p = 0; s_2active_p = 0; pk_encode = 0; header_st_p = 0;
      sendnewpy = 0; sendoldpy = 0; send0py = 0; mcu_wr_p = 0; mcu_flush_p = 0;
   endtask

   // Inputs are driven at negedge; outputs are sampled at the next negedge.
   task automatic tick();
      model_step();
      @(posedge clk_6M);
      @(negedge clk_6M);
      idle();
   endtask

   task automatic do_write(input int len, input int llid);
      mcu_wr_p = 1; mcu_wr_len = 10'(len); mcu_wr_llid = 2'(llid);
      tick();
   endtask

   task automatic do_header(input logic nw, input logic old, input logic z);
      pk_encode = 1; header_st_p = 1; sendnewpy = nw; sendoldpy = old; send0py = z;
      tick();
   endtask

   task automatic test_reset();
      rstz = 0;
      repeat (2) @(negedge clk_6M);
      model_clear();
      n_cmp++;
      if ({txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state0, buf_state1, buf_freed_p, wr_err_p} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got sel=%0d haspy=%0d len=%0d llid=%0d st0=%0d st1=%0d freed=%0d err=%0d, expected all 0",
                  txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state0, buf_state1, buf_freed_p, wr_err_p);
      end
      rstz = 1;
      @(negedge clk_6M);
      n_cmp++;
      if ({txbuf_sel, tx_haspy, buf_state0, buf_state1} !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_release: got sel=%0d haspy=%0d st0=%0d st1=%0d, expected 0", txbuf_sel, tx_haspy, buf_state0, buf_state1);
      end
   endtask

   task automatic test_send_new();
      do_write(27, 2);
      n_cmp++;
      if (buf_state1 !== LOADED || buf_state0 !== FREE) begin
         n_bad++;
         $display("FAIL write_target: got st0=%0d st1=%0d, expected st0=0 st1=1", buf_state0, buf_state1);
      end
      do_header(1, 0, 0);
      n_cmp++;
      if ({txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state1} !== {1'b1, 1'b1, 10'd27, 2'd2, INFL}) begin
         n_bad++;
         $display("FAIL send_new: got sel=%0d haspy=%0d len=%0d llid=%0d st1=%0d, expected 1 1 27 2 2",
                  txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state1);
      end
   endtask

   task automatic test_retransmit();
      for (int k = 0; k < 2; k++) begin
         do_header(0, 1, 0);
         n_cmp++;
         if ({txbuf_sel, tx_haspy, tx_pylen} !== {1'b1, 1'b1, 10'd27}) begin
            n_bad++;
            $display("FAIL resend_%0d: got sel=%0d haspy=%0d len=%0d, expected 1 1 27", k, txbuf_sel, tx_haspy, tx_pylen);
         end
      end
      do_write(10, 1);
      do_header(1, 0, 0);
      n_cmp++;
      if ({buf_state1, buf_freed_p, txbuf_sel, tx_haspy, tx_pylen} !== {FREE, 1'b1, 1'b0, 1'b1, 10'd10}) begin
         n_bad++;
         $display("FAIL ack_next: got st1=%0d freed=%0d sel=%0d haspy=%0d len=%0d, expected 0 1 0 1 10",
                  buf_state1, buf_freed_p, txbuf_sel, tx_haspy, tx_pylen);
      end
   endtask

   task automatic test_ordering();
      s_2active_p = 1;
      tick();
      do_write(5, 2);
      do_write(9, 2);
      do_header(1, 0, 0);
      n_cmp++;
      if (tx_pylen !== 10'd5 || txbuf_sel !== 1'b1) begin
         n_bad++;
         $display("FAIL order_first: got len=%0d sel=%0d, expected 5 1", tx_pylen, txbuf_sel);
      end
      do_header(1, 0, 0);
      n_cmp++;
      if (tx_pylen !== 10'd9 || txbuf_sel !== 1'b0) begin
         n_bad++;
         $display("FAIL order_second: got len=%0d sel=%0d, expected 9 0", tx_pylen, txbuf_sel);
      end
      do_write(12, 3);
      do_write(77, 3);
      n_cmp++;
      if ({wr_err_p, buf_state0, buf_state1} !== {1'b1, INFL, LOADED}) begin
         n_bad++;
         $display("FAIL write_full: got err=%0d st0=%0d st1=%0d, expected 1 2 1", wr_err_p, buf_state0, buf_state1);
      end
      tick();
      n_cmp++;
      if (wr_err_p !== 1'b0) begin
         n_bad++;
         $display("FAIL err_width: got err=%0d, expected 0", wr_err_p);
      end
   endtask

   task automatic test_send0();
      do_header(1, 0, 0);
      n_cmp++;
      if ({txbuf_sel, tx_pylen, buf_state1} !== {1'b1, 10'd12, INFL}) begin
         n_bad++;
         $display("FAIL send0_setup: got sel=%0d len=%0d st1=%0d, expected 1 12 2", txbuf_sel, tx_pylen, buf_state1);
      end
      do_header(0, 1, 1);
      n_cmp++;
      if ({tx_haspy, tx_pylen, tx_llid, buf_state1, buf_freed_p, txbuf_sel} !== {1'b1, 10'd0, 2'b01, FREE, 1'b1, 1'b1}) begin
         n_bad++;
         $display("FAIL send0: got haspy=%0d len=%0d llid=%0d st1=%0d freed=%0d sel=%0d, expected 1 0 1 0 1 1",
                  tx_haspy, tx_pylen, tx_llid, buf_state1, buf_freed_p, txbuf_sel);
      end
   endtask

   task automatic test_flush_decision();
      do_write(33, 2);
      do_header(1, 0, 0);
      do_write(44, 2);
      do_header(1, 0, 0);
      do_write(55, 1);
      mcu_flush_p = 1;
      do_header(1, 0, 0);
      n_cmp++;
      if ({buf_state0, buf_state1, buf_freed_p, tx_haspy, tx_pylen, txbuf_sel} !== {INFL, FREE, 1'b1, 1'b1, 10'd55, 1'b0}) begin
         n_bad++;
         $display("FAIL flush_decide: got st0=%0d st1=%0d freed=%0d haspy=%0d len=%0d sel=%0d, expected 2 0 1 1 55 0",
                  buf_state0, buf_state1, buf_freed_p, tx_haspy, tx_pylen, txbuf_sel);
      end
      tick();
      n_cmp++;
      if (buf_freed_p !== 1'b0) begin
         n_bad++;
         $display("FAIL freed_width: got freed=%0d, expected 0", buf_freed_p);
      end
   endtask

   task automatic test_activation();
      do_write(7, 2);
      s_2active_p = 1;
      mcu_wr_p = 1; mcu_wr_len = 10'd99; mcu_wr_llid = 2'd2;
      tick();
      n_cmp++;
      if ({buf_state0, buf_state1, txbuf_sel, tx_haspy, tx_pylen, wr_err_p, buf_freed_p} !== 19'd0) begin
         n_bad++;
         $display("FAIL activation: got st0=%0d st1=%0d sel=%0d haspy=%0d len=%0d err=%0d freed=%0d, expected all 0",
                  buf_state0, buf_state1, txbuf_sel, tx_haspy, tx_pylen, wr_err_p, buf_freed_p);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         m_2active_p = ($urandom_range(0, 99) == 0);
         s_2active_p = ($urandom_range(0, 99) == 0);
         header_st_p = ($urandom_range(0, 5) == 0);
         pk_encode   = ($urandom_range(0, 3) != 0);
         sendnewpy   = $urandom_range(0, 1);
         sendoldpy   = $urandom_range(0, 1);
         send0py     = ($urandom_range(0, 4) == 0);
         mcu_wr_p    = ($urandom_range(0, 2) == 0);
         mcu_wr_len  = 10'($urandom_range(0, 1021));
         mcu_wr_llid = 2'($urandom_range(1, 3));
         mcu_flush_p = ($urandom_range(0, 15) == 0);
         tick();
         n_cmp++;
         if ({txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state0, buf_state1, buf_freed_p, wr_err_p} !==
             {m_cur, m_haspy, m_pylen, m_txllid, m_st[0], m_st[1], m_freed, m_err}) begin
            n_bad++;
            $display("FAIL random_cycle_%0d: got sel=%0d haspy=%0d len=%0d llid=%0d st0=%0d st1=%0d freed=%0d err=%0d, expected %0d %0d %0d %0d %0d %0d %0d %0d",
                     c, txbuf_sel, tx_haspy, tx_pylen, tx_llid, buf_state0, buf_state1, buf_freed_p, wr_err_p,
                     m_cur, m_haspy, m_pylen, m_txllid, m_st[0], m_st[1], m_freed, m_err);
         end
      end
   endtask

   initial begin
      m_len[0] = 0; m_len[1] = 0; m_llid[0] = 0; m_llid[1] = 0;
      model_clear();
      @(negedge clk_6M);
      test_reset();
      test_send_new();
      test_retransmit();
      test_ordering();
      test_send0();
      test_flush_decision();
      test_activation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
